// File: rtl/debug_pkg.sv
// Shared definitions for the debug controller: FSM state encoding and command/frame byte values.
package debug_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_CONT,
    S_SNAP,
    S_LOAD,
    S_WAIT
  } state_t;

  localparam logic [7:0] CMD_STEP     = 8'h73;
  localparam logic [7:0] CMD_CONT     = 8'h63;
  localparam logic [7:0] FRAME_HEADER = 8'hA5;

endpackage

// File: rtl/debug_controller_if.sv
// UART byte-level link between the debug controller (master) and the UART receiver/transmitter (slave).
interface debug_controller_if;

  // rx_valid is a one-cycle pulse qualifying rx_data; there is no back-pressure on receive.
  // tx_start is a one-cycle request, only ever raised while tx_busy is low; tx_data is held
  // stable from tx_start until the transmitter answers with a one-cycle tx_done pulse.
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    input  rx_data, rx_valid, tx_busy, tx_done,
    output tx_data, tx_start
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, tx_done,
    input  tx_data, tx_start
  );

endinterface

// File: rtl/debug_frame_sender.sv
// Snapshot shadow register and byte-by-byte frame transmitter (LOAD/WAIT handshake, send counter).
// Optional DEBUG_HEADER_EN prefixes every frame with FRAME_HEADER.
module debug_frame_sender
  import debug_pkg::*;
#(
  parameter int DUMP_BYTES = 16
) (
  input  logic                    clock,
  input  logic                    resetGral,
  input  logic                    start,
  input  logic [8*DUMP_BYTES-1:0] dump_data,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic [7:0]              send_counter,
  output logic                    done,
  output state_t                  phase
);

`ifdef DEBUG_HEADER_EN
  localparam int FRAME_LEN = DUMP_BYTES + 1;
`else
  localparam int FRAME_LEN = DUMP_BYTES;
`endif
  localparam logic [7:0] LAST_INDEX = 8'(FRAME_LEN - 1);

  logic [8*DUMP_BYTES-1:0] shadow;
  logic [7:0]              index;
  logic [7:0]              first_byte;
  logic [7:0]              data_index;
  logic [7:0]              next_byte;
  logic                    last;

  // data_index is the shadow byte that follows frame position index.
`ifdef DEBUG_HEADER_EN
  assign first_byte = FRAME_HEADER;
  assign data_index = index;
`else
  assign first_byte = dump_data[7:0];
  assign data_index = index + 8'd1;
`endif

  always_comb begin
    next_byte = 8'h00;
    for (int k = 0; k < DUMP_BYTES; k++) begin
      if (data_index == 8'(k)) next_byte = shadow[8*k +: 8];
    end
  end

  assign last     = (index == LAST_INDEX);
  assign tx_start = (phase == S_LOAD) && !tx_busy;
  assign done     = (phase == S_WAIT) && tx_done && last;

  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      phase        <= S_IDLE;
      shadow       <= '0;
      index        <= 8'd0;
      tx_data      <= 8'h00;
      send_counter <= 8'd0;
    end else begin
      case (phase)
        S_IDLE: begin
          if (start) begin
            shadow       <= dump_data;
            index        <= 8'd0;
            send_counter <= 8'd0;
            tx_data      <= first_byte;
            phase        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!tx_busy) phase <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            send_counter <= send_counter + 8'd1;
            index        <= index + 8'd1;
            if (last) begin
              phase <= S_IDLE;
            end else begin
              tx_data <= next_byte;
              phase   <= S_LOAD;
            end
          end
        end
        default: phase <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_controller.sv
// Command-driven debug FSM: single-step / continuous run of the datapath, then a snapshot frame over UART.
// Define DEBUG_HEADER_EN to prefix each frame with a 0xA5 header byte.
module debug_controller
  import debug_pkg::*;
#(
  parameter int DUMP_BYTES = 16
) (
  input  logic                    clock,
  input  logic                    resetGral,
  debug_controller_if.master      uart,
  input  logic [8*DUMP_BYTES-1:0] dump_data,
  input  logic                    pipe_halt,
  output logic                    pipe_enable,
  output logic                    led_idle,
  output logic                    led_step,
  output logic                    led_send,
  output logic                    led_cont,
  output logic [7:0]              send_counter,
  output logic                    sent_flag,
  output state_t                  fsm_state
);

  state_t     state;
  state_t     sender_phase;
  logic       frame_start;
  logic       frame_done;
  logic [7:0] frame_tx_data;
  logic       frame_tx_start;

  assign frame_start = (state == S_SNAP);

  // While a frame is in flight the top sits in S_LOAD; the sender's phase tells LOAD from WAIT.
  assign fsm_state = (state == S_LOAD) ? sender_phase : state;

  assign uart.tx_data  = frame_tx_data;
  assign uart.tx_start = frame_tx_start;

  debug_frame_sender #(.DUMP_BYTES(DUMP_BYTES)) u_sender (
    .clock        (clock),
    .resetGral    (resetGral),
    .start        (frame_start),
    .dump_data    (dump_data),
    .tx_busy      (uart.tx_busy),
    .tx_done      (uart.tx_done),
    .tx_data      (frame_tx_data),
    .tx_start     (frame_tx_start),
    .send_counter (send_counter),
    .done         (frame_done),
    .phase        (sender_phase)
  );

  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      state       <= S_IDLE;
      pipe_enable <= 1'b0;
      sent_flag   <= 1'b0;
      led_idle    <= 1'b1;
      led_step    <= 1'b0;
      led_cont    <= 1'b0;
      led_send    <= 1'b0;
    end else begin
      sent_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (uart.rx_valid && uart.rx_data == CMD_STEP) begin
            state       <= S_STEP;
            pipe_enable <= 1'b1;
            led_idle    <= 1'b0;
            led_step    <= 1'b1;
          end else if (uart.rx_valid && uart.rx_data == CMD_CONT) begin
            state       <= S_CONT;
            pipe_enable <= 1'b1;
            led_idle    <= 1'b0;
            led_cont    <= 1'b1;
          end
        end
        S_STEP: begin
          state       <= S_SNAP;
          pipe_enable <= 1'b0;
          led_step    <= 1'b0;
          led_send    <= 1'b1;
        end
        S_CONT: begin
          if (pipe_halt) begin
            state       <= S_SNAP;
            pipe_enable <= 1'b0;
            led_cont    <= 1'b0;
            led_send    <= 1'b1;
          end
        end
        S_SNAP: state <= S_LOAD;
        S_LOAD: begin
          if (frame_done) begin
            state     <= S_IDLE;
            sent_flag <= 1'b1;
            led_send  <= 1'b0;
            led_idle  <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          pipe_enable <= 1'b0;
          led_idle    <= 1'b1;
          led_step    <= 1'b0;
          led_cont    <= 1'b0;
          led_send    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Self-checking bench for debug_controller: datapath and UART transmitter models, frame scoreboard.
// Build with DEBUG_HEADER_EN defined to expect the 0xA5 header byte.
module tb_debug_controller;
  import debug_pkg::*;

  localparam int DB = 4;
  localparam int W  = 8*DB;
`ifdef DEBUG_HEADER_EN
  localparam int FRAME = DB + 1;
`else
  localparam int FRAME = DB;
`endif

  logic         clock;
  logic         resetGral;
  logic [W-1:0] dump_data;
  logic         pipe_halt;
  logic         pipe_enable;
  logic         led_idle, led_step, led_send, led_cont;
  logic [7:0]   send_counter;
  logic         sent_flag;
  state_t       fsm_state;

  debug_controller_if u();

  logic tx_active;
  logic hold_busy;
  assign u.tx_busy = tx_active | hold_busy;

  debug_controller #(.DUMP_BYTES(DB)) dut (
    .clock        (clock),
    .resetGral    (resetGral),
    .uart         (u),
    .dump_data    (dump_data),
    .pipe_halt    (pipe_halt),
    .pipe_enable  (pipe_enable),
    .led_idle     (led_idle),
    .led_step     (led_step),
    .led_send     (led_send),
    .led_cont     (led_cont),
    .send_counter (send_counter),
    .sent_flag    (sent_flag),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- checking ----------------
  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- datapath model: value = base + delta * enabled_cycles ----------------
  logic [W-1:0] dp_base, dp_delta, scramble_val;
  logic         scramble;
  int unsigned  dp_steps;

  assign dump_data = scramble ? scramble_val : dp_base + dp_delta * W'(dp_steps);

  initial begin : datapath
    logic pe_prev;
    dp_steps     = 0;
    scramble_val = '0;
    forever begin
      @(negedge clock);
      pe_prev = pipe_enable;
      @(posedge clock);
      #1;
      if (pe_prev) dp_steps++;
      scramble_val = $urandom();
    end
  end

  // ---------------- event monitor ----------------
  int pe_cnt, flag_cnt, busy_start_err;
  initial begin : monitor
    pe_cnt = 0; flag_cnt = 0; busy_start_err = 0;
    forever begin
      @(negedge clock);
      if (pipe_enable) pe_cnt++;
      if (sent_flag) flag_cnt++;
      if (u.tx_start && u.tx_busy) busy_start_err++;
    end
  end

  // ---------------- UART transmitter model ----------------
  logic [7:0] obs_q[$];
  int start_cnt, done_cnt, data_hold_err;
  initial begin : tx_model
    logic [7:0] held;
    tx_active = 1'b0; u.tx_done = 1'b0;
    start_cnt = 0; done_cnt = 0; data_hold_err = 0;
    forever begin
      @(negedge clock);
      if (u.tx_start) begin
        obs_q.push_back(u.tx_data);
        start_cnt++;
        held = u.tx_data;
        @(posedge clock); #1 tx_active = 1'b1;
        repeat ($urandom_range(1, 4)) begin
          @(negedge clock);
          if (u.tx_data !== held || u.tx_start) data_hold_err++;
        end
        @(posedge clock); #1;
        tx_active = 1'b0; u.tx_done = 1'b1; done_cnt++;
        @(posedge clock); #1 u.tx_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] b);
    @(posedge clock); #1;
    u.rx_data = b; u.rx_valid = 1'b1;
    @(posedge clock); #1;
    u.rx_valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic run_frame(input string tag, input logic [7:0] cmd, input int halt_at,
                           input int hold, input bit inject);
    logic [W-1:0] snap;
    int steps, pe0, flag0, start0, obs0;
    bit got_flag, injected, idle_at_flag;
    steps = (cmd == 8'h73) ? 1 : halt_at;
    snap  = dp_base + dp_delta * W'(dp_steps + steps);
    exp_q.delete();
`ifdef DEBUG_HEADER_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 0; i < DB; i++) exp_q.push_back(snap[8*i +: 8]);
    pe0 = pe_cnt; flag0 = flag_cnt; start0 = start_cnt; obs0 = obs_q.size();

    hold_busy = (hold > 0);
    send_cmd(cmd);
    if (cmd == 8'h63) begin
      repeat (halt_at - 1) begin @(posedge clock); #1; end
      pipe_halt = 1'b1;
      @(posedge clock); #1;
      pipe_halt = 1'b0;
    end
    if (hold > 0) begin
      @(posedge clock); #1;
      @(posedge clock); #1;
      for (int c = 0; c < hold; c++) begin
        @(negedge clock);
        check_eq({tag, "_held_start"}, u.tx_start, 1'b0);
        check_eq({tag, "_held_state"}, fsm_state, S_LOAD);
        @(posedge clock); #1;
      end
      hold_busy = 1'b0;
    end

    got_flag = 0; injected = 0; idle_at_flag = 0;
    for (int c = 0; c < 3000 && !got_flag; c++) begin
      @(negedge clock);
      if (sent_flag) begin
        got_flag     = 1;
        idle_at_flag = led_idle;
      end else if (u.tx_start) begin
        scramble = 1'b1;
        if (inject && !injected) begin
          injected = 1;
          @(posedge clock); #1;
          u.rx_data = 8'h73; u.rx_valid = 1'b1;
          @(posedge clock); #1;
          u.rx_valid = 1'b0;
        end
      end
    end
    scramble = 1'b0;
    check_eq({tag, "_flag_seen"}, got_flag, 1'b1);
    check_eq({tag, "_idle_at_flag"}, idle_at_flag, 1'b1);

    repeat (10) @(negedge clock);
    check_eq({tag, "_nbytes"}, obs_q.size() - obs0, FRAME);
    for (int i = 0; i < FRAME; i++) begin
      logic [7:0]  e;
      logic [31:0] g;
      e = exp_q.pop_front();
      g = (obs0 + i < obs_q.size()) ? 32'(obs_q[obs0 + i]) : 32'hDEAD;
      check_eq($sformatf("%s_byte%0d", tag, i), g, e);
    end
    check_eq({tag, "_counter"}, send_counter, FRAME);
    check_eq({tag, "_flag_pulses"}, flag_cnt - flag0, 1);
    check_eq({tag, "_pe_cycles"}, pe_cnt - pe0, steps);
    check_eq({tag, "_starts"}, start_cnt - start0, FRAME);
    check_eq({tag, "_idle"}, led_idle, 1'b1);
    check_eq({tag, "_state"}, fsm_state, S_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [7:0] cmd;
    int pe0, start0, d0;
    bit got;
    n_checks = 0; n_fail = 0;
    resetGral = 1'b0; u.rx_valid = 1'b0; u.rx_data = 8'h00;
    pipe_halt = 1'b0; hold_busy = 1'b0; scramble = 1'b0;
    dp_base = '0; dp_delta = '0;

    repeat (3) @(negedge clock);
    check_eq("rst_led_idle", led_idle, 1'b1);
    check_eq("rst_other_leds", {led_step, led_send, led_cont}, 3'b000);
    check_eq("rst_pipe_enable", pipe_enable, 1'b0);
    check_eq("rst_tx_start", u.tx_start, 1'b0);
    check_eq("rst_tx_data", u.tx_data, 8'h00);
    check_eq("rst_counter", send_counter, 8'd0);
    check_eq("rst_sent_flag", sent_flag, 1'b0);
    resetGral = 1'b1;
    repeat (2) @(negedge clock);

    dp_base = 32'h44332211; dp_delta = '0;
    run_frame("step", 8'h73, 0, 0, 0);

    dp_base = $urandom(); dp_delta = $urandom();
    run_frame("cont", 8'h63, 10, 0, 0);

    pe0 = pe_cnt; start0 = start_cnt;
    send_cmd(8'h41);
    repeat (8) @(negedge clock);
    check_eq("ignore_pe", pe_cnt - pe0, 0);
    check_eq("ignore_starts", start_cnt - start0, 0);
    check_eq("ignore_idle", led_idle, 1'b1);

    dp_base = $urandom(); dp_delta = $urandom_range(1, 255);
    run_frame("drop", 8'h73, 0, 0, 1);

    dp_base = $urandom(); dp_delta = $urandom_range(1, 255);
    run_frame("hold", 8'h73, 0, 5, 0);

    for (int r = 0; r < 8; r++) begin
      dp_base  = $urandom();
      dp_delta = $urandom_range(0, 255);
      cmd      = ($urandom_range(0, 1) == 1) ? 8'h73 : 8'h63;
      run_frame($sformatf("rand%0d", r), cmd, $urandom_range(1, 15), 0, $urandom_range(0, 1) == 1);
    end

    dp_base = $urandom(); dp_delta = 1;
    d0 = done_cnt; start0 = start_cnt;
    send_cmd(8'h73);
    got = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clock);
      if (done_cnt - d0 >= 2) got = 1;
    end
    check_eq("midrst_two_done", got, 1'b1);
    check_eq("midrst_starts_before", start_cnt - start0, 2);
    resetGral = 1'b0;
    #1;
    check_eq("midrst_led_idle", led_idle, 1'b1);
    check_eq("midrst_state", fsm_state, S_IDLE);
    check_eq("midrst_counter", send_counter, 8'd0);
    check_eq("midrst_tx_start", u.tx_start, 1'b0);
    check_eq("midrst_pipe_enable", pipe_enable, 1'b0);
    start0 = start_cnt;
    repeat (3) @(negedge clock);
    resetGral = 1'b1;
    repeat (30) @(negedge clock);
    check_eq("midrst_no_restart", start_cnt - start0, 0);
    check_eq("midrst_idle_after", led_idle, 1'b1);

    dp_base = $urandom(); dp_delta = $urandom_range(1, 255);
    run_frame("recover", 8'h73, 0, 0, 0);

    check_eq("start_while_busy", busy_start_err, 0);
    check_eq("tx_data_held", data_hold_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_controller.md
# debug_controller

Command-driven debug FSM between the UART byte interfaces and the pipelined datapath. It decodes command bytes from the UART receiver and gates the datapath clock enable for single-step or continuous run. When the datapath stops, it captures a snapshot of the pipeline state and streams it byte by byte to the UART transmitter. It also drives the idle/step/send/cont LEDs and the send counter and sent flag debug outputs.

## Interface
- DUMP_BYTES, 16: bytes of pipeline state per frame; legal range 1..254.
- clock  in  1  system clock; all logic on the rising edge.
- resetGral  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle.
- tx_data  out  8  byte to the UART transmitter.
- tx_start  out  1  one-cycle pulse that requests transmission of tx_data.
- tx_busy  in  1  transmitter busy; tx_start is never asserted while this is high.
- tx_done  in  1  one-cycle pulse when the transmitter finishes the current byte.
- dump_data  in  8*DUMP_BYTES  flattened pipeline state; byte k is dump_data[8k+7:8k].
- pipe_halt  in  1  datapath reached its halt instruction.
- pipe_enable  out  1  datapath clock enable (registered).
- led_idle, led_step, led_send, led_cont  out  1 each  one-hot state indicators.
- send_counter  out  8  bytes completed in the current or last frame.
- sent_flag  out  1  one-cycle pulse when a frame completes.

## Operation
- States:
  - IDLE: waiting for a command.
  - STEP: pipe_enable=1 for exactly one cycle.
  - CONT: pipe_enable=1 until the datapath halts.
  - SNAP: capture dump_data.
  - LOAD: issue the next byte.
  - WAIT: wait for the transmitter to finish the byte.
- Transitions:
  - IDLE, rx_valid with rx_data=0x73 ('s') → STEP.
  - IDLE, rx_valid with rx_data=0x63 ('c') → CONT.
  - IDLE, any other byte: ignored.
  - STEP → SNAP unconditionally after 1 cycle.
  - CONT, pipe_halt=1 → SNAP. pipe_enable is 0 from the cycle after pipe_halt is sampled.
  - SNAP: load shadow register ← dump_data, byte index ← 0, send_counter ← 0 → LOAD.
  - LOAD, tx_busy=0: tx_start=1, tx_data=shadow[index] → WAIT.
  - LOAD, tx_busy=1: stay in LOAD with no tx_start.
  - WAIT, tx_done=1: send_counter+1 and index+1. If the frame is not finished → LOAD. If it is finished → IDLE with a one-cycle sent_flag pulse.
- Frame content comes from the shadow register only. Changes on dump_data after SNAP do not affect the frame.
- Bytes are sent LSB-byte first: index 0 → dump_data[7:0].
- rx_valid outside IDLE is dropped; commands are not queued.
- pipe_halt outside CONT is ignored.
- tx_data holds its value from tx_start until tx_done.
- LED mapping:
  - led_idle: IDLE.
  - led_step: STEP.
  - led_cont: CONT.
  - led_send: SNAP, LOAD or WAIT.
- send_counter holds its final value until the next SNAP; 8-bit, no wrap within the legal DUMP_BYTES range.
- Reset values (resetGral low, async): state IDLE, pipe_enable 0, tx_start 0, tx_data 0x00, send_counter 0, sent_flag 0, led_idle 1, other LEDs 0, shadow register 0.
- Reset mid-frame abandons the frame; no further tx_start is issued.

## Timing
- rx_valid ('s') at cycle n → STEP at n+1 with pipe_enable=1 → SNAP at n+2 → LOAD at n+3.
- The snapshot sees the state after the single datapath step.
- pipe_halt sampled at n → pipe_enable=0 at n+1 (SNAP) → LOAD at n+2.
- LOAD to tx_start: same cycle when tx_busy=0.
- tx_done at cycle m → next tx_start no earlier than m+1. Minimum per-byte overhead is 2 cycles plus transmitter time.
- sent_flag is asserted in the first IDLE cycle after the last tx_done, for 1 cycle.

## Configuration
- DEBUG_HEADER_EN defined:
  - Each frame starts with byte 0xA5 before the state bytes.
  - Frame length is DUMP_BYTES+1.
  - send_counter includes the header byte.
- DEBUG_HEADER_EN undefined: the frame is exactly DUMP_BYTES state bytes and there is no header logic.

## Structure
- Shared package debug_pkg holds:
  - the state enum;
  - CMD_STEP=0x73 and CMD_CONT=0x63;
  - FRAME_HEADER=0xA5.
- Sub-module debug_frame_sender owns the shadow register, byte index, the LOAD/WAIT handshake and send_counter.
- The top FSM issues a start strobe to debug_frame_sender and receives a done strobe back.

## Test plan
- Reset: hold resetGral low → led_idle=1, pipe_enable=0, tx_start=0, send_counter=0.
- Single step:
  - Stimulus: DUMP_BYTES=4, dump_data=0x44332211, rx 0x73.
  - Response: pipe_enable high exactly 1 cycle; tx bytes 0x11, 0x22, 0x33, 0x44; send_counter=4; one sent_flag pulse; return to IDLE.
- Continuous run: rx 0x63, pipe_halt at cycle 10 → pipe_enable high for cycles 1..10 and low at 11; frame follows.
- Dropped inputs: rx 0x41 in IDLE → no state change. rx 0x73 during WAIT → dropped, and no step after the frame completes.
- Handshake and snapshot:
  - tx_busy held high for 5 cycles in LOAD → no tx_start until it drops.
  - dump_data changed mid-frame → the sent bytes equal the SNAP-time value.
- Reset mid-frame: resetGral low after byte 2 → immediate IDLE, counter 0, no tx_start.
- Header (DEBUG_HEADER_EN defined): first byte 0xA5, send_counter=5 for DUMP_BYTES=4.
